// File: rtl/cordic_lut_loader_if.sv
// -----------------------------------------------------------------------------
// cordic_lut_loader_if
//
// Purpose: bundles the two buses the LUT loader sits between.
//   Host stream : in_valid / in_data / in_ready. These are 48-bit LUT entries
//                 delivered in index order 0..63.
//   Core side   : lut_wen / lut_index / lut_data / core_reset carry the LUT
//                 write port and the core reset. core_wen_out is the core's
//                 output-valid flag.
//
// Modports:
//   master : the loader. It drives in_ready and the core LUT port, and
//            observes in_valid, in_data and core_wen_out.
//   slave  : the environment (host + CORDIC core). It has the opposite
//            directions.
// -----------------------------------------------------------------------------
interface cordic_lut_loader_if;
    logic        in_valid;
    logic [47:0] in_data;
    logic        in_ready;
    logic        lut_wen;      // active-low: 0 = write, 1 = run
    logic [5:0]  lut_index;
    logic [47:0] lut_data;
    logic        core_reset;   // active-low: 0 = core held in reset
    logic        core_wen_out;

    modport master (
        input  in_valid, in_data, core_wen_out,
        output in_ready, lut_wen, lut_index, lut_data, core_reset
    );

    modport slave (
        output in_valid, in_data, core_wen_out,
        input  in_ready, lut_wen, lut_index, lut_data, core_reset
    );
endinterface

// File: rtl/cordic_lut_loader.sv
// -----------------------------------------------------------------------------
// cordic_lut_loader
//
// Purpose: streams 64 host-supplied 48-bit entries into a CORDIC core's LUT.
// The core is held in reset while the table is written. After the last entry
// there is one flush cycle and a two-cycle restart window. The core is then
// released, and the loader measures the cycles from release to the core's
// first valid output.
//
// Ports:
//   clk        : sole clock, rising edge.
//   reset      : asynchronous, active-high reset.
//   start      : one-cycle request to (re)load. It is honoured only in
//                IDLE and RUN.
//   bus        : cordic_lut_loader_if.master. It carries the host stream and
//                the core LUT write port / core reset / core_wen_out.
//   busy       : high while loading, flushing or restarting.
//   first_lat  : release-to-first-valid latency, saturating at 255.
//   done       : one-cycle pulse, coincident with a new first_lat value.
//
// All outputs come straight from flops. Each one is loaded from the value it
// must take in the *next* state, so it changes on the same edge as the state.
// -----------------------------------------------------------------------------
module cordic_lut_loader (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    cordic_lut_loader_if.master bus,
    output logic                busy,
    output logic [7:0]          first_lat,
    output logic                done
);

    localparam logic [5:0] LAST_IDX = 6'd63;
    localparam logic [7:0] LAT_MAX  = 8'd255;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_FLUSH   = 3'd2,
        S_RESTART = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_wr_cnt;        // index of the next entry to accept
    logic        r_restart_cnt;   // 0 = first RESTART cycle, 1 = second
    logic [7:0]  r_lat_cnt;       // RUN cycles seen without core_wen_out
    logic        r_captured;      // latency already captured for this run

    logic        r_in_ready;
    logic        r_lut_wen;
    logic [5:0]  r_lut_index;
    logic [47:0] r_lut_data;
    logic        r_core_reset;
    logic        r_busy;
    logic [7:0]  r_first_lat;
    logic        r_done;

    logic        w_accept;
    logic        w_capture;
    logic        w_enter_load;
    logic        w_enter_run;
    logic        w_in_ready_nxt;
    logic        w_lut_wen_nxt;
    logic        w_core_reset_nxt;
    logic        w_busy_nxt;

    // r_in_ready is high only in LOAD, so it alone qualifies the handshake.
    // A start in IDLE that arrives with in_valid therefore cannot slip an
    // entry in.
    assign w_accept  = r_in_ready & bus.in_valid;

    // core_wen_out only matters in RUN, and only until the first capture.
    assign w_capture = (r_state == S_RUN) & bus.core_wen_out & ~r_captured;

    assign w_enter_load = (w_next_state == S_LOAD) && (r_state != S_LOAD);
    assign w_enter_run  = (w_next_state == S_RUN)  && (r_state != S_RUN);

    // -------------------------------------------------------------------------
    // Next-state and next-output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        w_next_state     = r_state;
        w_in_ready_nxt   = 1'b0;
        w_lut_wen_nxt    = 1'b1;
        w_core_reset_nxt = 1'b0;
        w_busy_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                // start is deliberately not examined here.
                if (w_accept && (r_wr_cnt == LAST_IDX)) w_next_state = S_FLUSH;
            end
            S_FLUSH: begin
                w_next_state = S_RESTART;
            end
            S_RESTART: begin
                if (r_restart_cnt) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (start) w_next_state = S_LOAD;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // NOTE: blocking assignments are correct in combinational logic.
        // This case reads the w_next_state value just computed above.
        case (w_next_state)
            S_LOAD: begin
                w_in_ready_nxt = 1'b1;
                w_lut_wen_nxt  = 1'b0;
                w_busy_nxt     = 1'b1;
            end
            S_FLUSH: begin
                // The LUT stays in write mode for one extra cycle, so that
                // entry 63 is written with a full cycle of settled address
                // and data.
                w_lut_wen_nxt  = 1'b0;
                w_busy_nxt     = 1'b1;
            end
            S_RESTART: begin
                w_busy_nxt     = 1'b1;
            end
            S_RUN: begin
                w_core_reset_nxt = 1'b1;
            end
            default: begin
                // IDLE: run mode with the core held in reset (the defaults).
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments, so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // -------------------------------------------------------------------------
    // Write path: entry counter and LUT write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: lut_index/lut_data are ordinary output flops, not a memory.
        // They drive the core directly and need a defined value out of
        // reset, so they are reset like everything else.
        if (reset) begin
            r_wr_cnt     <= 6'd0;
            r_lut_index  <= 6'd0;
            r_lut_data   <= 48'd0;
            r_in_ready   <= 1'b0;
            r_lut_wen    <= 1'b1;
            r_core_reset <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_in_ready   <= w_in_ready_nxt;
            r_lut_wen    <= w_lut_wen_nxt;
            r_core_reset <= w_core_reset_nxt;
            r_busy       <= w_busy_nxt;

            if (w_enter_load) begin
                r_wr_cnt <= 6'd0;
            end else if (w_accept) begin
                // Entry 63 wraps the counter back to 0.
                r_wr_cnt    <= r_wr_cnt + 6'd1;
                r_lut_index <= r_wr_cnt;
                r_lut_data  <= bus.in_data;
            end
            // Between accepts, index/data simply hold. The core may rewrite
            // the same entry while the host stalls; that is harmless.
        end
    end

    // -------------------------------------------------------------------------
    // Restart window: two cycles with the core still in reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       r_restart_cnt <= 1'b0;
        else if (r_state == S_RESTART)   r_restart_cnt <= ~r_restart_cnt;
        else                             r_restart_cnt <= 1'b0;
    end

    // -------------------------------------------------------------------------
    // First-output latency measurement
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_cnt   <= 8'd0;
            r_captured  <= 1'b0;
            r_first_lat <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_capture;

            if (w_enter_run) begin
                // The first RUN cycle sees a count of 0. first_lat keeps the
                // previous result until a new capture replaces it.
                r_lat_cnt  <= 8'd0;
                r_captured <= 1'b0;
            end else if (w_capture) begin
                r_captured  <= 1'b1;
                r_first_lat <= r_lat_cnt;
            end else if ((r_state == S_RUN) && !r_captured && (r_lat_cnt != LAT_MAX)) begin
                r_lat_cnt <= r_lat_cnt + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign bus.in_ready   = r_in_ready;
    assign bus.lut_wen    = r_lut_wen;
    assign bus.lut_index  = r_lut_index;
    assign bus.lut_data   = r_lut_data;
    assign bus.core_reset = r_core_reset;
    assign busy           = r_busy;
    assign first_lat      = r_first_lat;
    assign done           = r_done;

endmodule

// File: tb/tb_cordic_lut_loader.sv
// -----------------------------------------------------------------------------
// tb_cordic_lut_loader
//
// Directed bench for cordic_lut_loader. A behavioural model tracks the
// loader in terms of "entries accepted so far", "cycles since the last entry"
// and "age of the current run". The DUT outputs are compared against it on
// every falling edge. Literal expectations at the key moments pin the model.
// -----------------------------------------------------------------------------
module tb_cordic_lut_loader;

    typedef enum int {M_IDLE, M_LOAD, M_POST, M_RUN} mode_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic [7:0] first_lat;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cordic_lut_loader_if bus_if ();

    cordic_lut_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus_if),
        .busy      (busy),
        .first_lat (first_lat),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    mode_t       m_mode;
    int          m_next_idx;   // how many entries of this load are already in
    int          m_post;       // cycles since the last entry was accepted
    int          m_run_age;    // cycles since the core was released
    logic [5:0]  m_idx;
    logic [47:0] m_data;
    logic        m_captured;
    logic [7:0]  m_first_lat;
    logic        m_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode      <= M_IDLE;
            m_next_idx  <= 0;
            m_post      <= 0;
            m_run_age   <= 0;
            m_idx       <= 6'd0;
            m_data      <= 48'd0;
            m_captured  <= 1'b0;
            m_first_lat <= 8'd0;
            m_done      <= 1'b0;
        end else begin
            m_done <= 1'b0;
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode     <= M_LOAD;
                    m_next_idx <= 0;
                end
                M_LOAD: if (bus_if.in_valid) begin
                    m_idx      <= 6'(m_next_idx);
                    m_data     <= bus_if.in_data;
                    m_next_idx <= (m_next_idx + 1) % 64;
                    if (m_next_idx == 63) begin
                        m_mode <= M_POST;
                        m_post <= 0;
                    end
                end
                M_POST: begin
                    // One flush cycle plus two restart cycles, then release.
                    if (m_post == 2) begin
                        m_mode     <= M_RUN;
                        m_run_age  <= 0;
                        m_captured <= 1'b0;
                    end else begin
                        m_post <= m_post + 1;
                    end
                end
                M_RUN: begin
                    if (!m_captured && bus_if.core_wen_out) begin
                        m_captured  <= 1'b1;
                        m_first_lat <= (m_run_age > 255) ? 8'd255 : 8'(m_run_age);
                        m_done      <= 1'b1;
                    end
                    m_run_age <= m_run_age + 1;
                    if (start) begin
                        m_mode     <= M_LOAD;
                        m_next_idx <= 0;
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------- compare process
    always @(negedge clk) begin
        check("in_ready",   64'(bus_if.in_ready),   64'(m_mode == M_LOAD));
        check("lut_wen",    64'(bus_if.lut_wen),
              64'(!(m_mode == M_LOAD || (m_mode == M_POST && m_post == 0))));
        check("core_reset", 64'(bus_if.core_reset), 64'(m_mode == M_RUN));
        check("busy",       64'(busy),              64'(m_mode == M_LOAD || m_mode == M_POST));
        check("lut_index",  64'(bus_if.lut_index),  64'(m_idx));
        check("lut_data",   64'(bus_if.lut_data),   64'(m_data));
        check("first_lat",  64'(first_lat),         64'(m_first_lat));
        check("done",       64'(done),              64'(m_done));
    end

    // -------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lut_wen"},    64'(bus_if.lut_wen),    64'd1);
        check({tag, "_core_reset"}, 64'(bus_if.core_reset), 64'd0);
        check({tag, "_lut_index"},  64'(bus_if.lut_index),  64'd0);
        check({tag, "_lut_data"},   64'(bus_if.lut_data),   64'd0);
        check({tag, "_in_ready"},   64'(bus_if.in_ready),   64'd0);
        check({tag, "_busy"},       64'(busy),              64'd0);
        check({tag, "_first_lat"},  64'(first_lat),         64'd0);
        check({tag, "_done"},       64'(done),              64'd0);
    endtask

    // Present entries base+0..base+63 back to back. Optional events:
    // a 3-cycle in_valid gap after entry stall_after, a start pulse
    // alongside entry start_at, and reset asserted while entry reset_at is
    // offered (the task returns right after that). t0 is the cycle count at
    // the start of the first accept cycle.
    task automatic load(input logic [47:0] base, input int stall_after,
                        input int start_at, input int reset_at, output int t0);
        t0 = cyc;
        for (int k = 0; k < 64; k++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = base + 48'(k);
            if (k == reset_at) begin
                #1 reset = 1'b1;
                #1 check_reset_outputs("abort");
                bus_if.in_valid = 1'b0;
                return;
            end
            if (k == start_at) start = 1'b1;
            tick();
            start = 1'b0;
            if (k == stall_after) begin
                bus_if.in_valid = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_in_ready",  64'(bus_if.in_ready),  64'd1);
                    check("stall_lut_index", 64'(bus_if.lut_index), 64'(k));
                end
            end
        end
        bus_if.in_valid = 1'b0;
        // FLUSH cycle: entry 63 held, still writing, no longer accepting.
        check("flush_lut_index", 64'(bus_if.lut_index), 64'd63);
        check("flush_lut_data",  64'(bus_if.lut_data),  64'(base + 48'd63));
        check("flush_lut_wen",   64'(bus_if.lut_wen),   64'd0);
        check("flush_in_ready",  64'(bus_if.in_ready),  64'd0);
        check("flush_busy",      64'(busy),             64'd1);
    endtask

    // Wait (bounded) for core release and check how long the load took.
    task automatic wait_run(input int t0, input int exp_gap);
        int gap;
        gap = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_if.core_reset === 1'b1) begin
                gap = cyc - t0;
                break;
            end
        end
        check("run_entry_gap", 64'(gap), 64'(exp_gap));
        check("run_lut_wen",   64'(bus_if.lut_wen), 64'd1);
        check("run_busy",      64'(busy),           64'd0);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int t0;
        bus_if.in_valid     = 1'b0;
        bus_if.in_data      = 48'd0;
        bus_if.core_wen_out = 1'b0;

        repeat (2) tick();
        check_reset_outputs("por");
        reset = 1'b0;
        tick();

        // Plain load, then a 22-cycle release-to-valid latency.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_in_ready", 64'(bus_if.in_ready), 64'd1);
        check("load_lut_wen",  64'(bus_if.lut_wen),  64'd0);
        load(48'd0, -1, -1, -1, t0);
        wait_run(t0, 67);
        repeat (22) tick();
        bus_if.core_wen_out = 1'b1;
        tick();
        check("lat22_done",      64'(done),      64'd1);
        check("lat22_first_lat", 64'(first_lat), 64'd22);
        bus_if.core_wen_out = 1'b0;
        tick();
        check("lat22_done_off",  64'(done),      64'd0);
        bus_if.core_wen_out = 1'b1;
        tick();
        check("toggle_no_done",  64'(done),      64'd0);
        check("toggle_lat_hold", 64'(first_lat), 64'd22);
        bus_if.core_wen_out = 1'b0;
        tick();

        // start in RUN: reload with a stall and an ignored start, then
        // a saturated latency.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reload_core_reset", 64'(bus_if.core_reset), 64'd0);
        check("reload_lut_wen",    64'(bus_if.lut_wen),    64'd0);
        check("reload_in_ready",   64'(bus_if.in_ready),   64'd1);
        check("reload_lat_kept",   64'(first_lat),         64'd22);
        load(48'd0, 10, 30, -1, t0);
        wait_run(t0, 70);
        repeat (300) tick();
        bus_if.core_wen_out = 1'b1;
        tick();
        check("sat_first_lat", 64'(first_lat), 64'd255);
        check("sat_done",      64'(done),      64'd1);
        bus_if.core_wen_out = 1'b0;
        tick();

        // Reset in the middle of a load, then a fresh load from index 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        load(48'd0, -1, -1, 40, t0);
        tick();
        check_reset_outputs("held");
        reset = 1'b0;
        tick();
        // start and in_valid together in IDLE: nothing may be accepted.
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 48'hABCDEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("idle_start_no_accept_idx",  64'(bus_if.lut_index), 64'd0);
        check("idle_start_no_accept_data", 64'(bus_if.lut_data),  64'd0);
        check("idle_start_in_ready",       64'(bus_if.in_ready),  64'd1);
        // core_wen_out high throughout the load must have no effect there.
        bus_if.core_wen_out = 1'b1;
        load(48'hA5A5_0000_0000, -1, -1, -1, t0);
        check("fresh_first_lat_zero", 64'(first_lat), 64'd0);
        wait_run(t0, 67);
        tick();
        check("lat0_done",      64'(done),      64'd1);
        check("lat0_first_lat", 64'(first_lat), 64'd0);
        bus_if.core_wen_out = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
